// File: rtl/parallel_converter_n_to_1.sv
// -----------------------------------------------------------------------------
// parallel_converter_n_to_1
//
// Serializes an N_LANES-wide bus of coded blocks into single blocks, one block
// per accepted strobe (i_enable & i_valid). Lane 0 sits in the bus MSBs and is
// emitted first. i_data is captured only on the strobe that starts a word. The
// remaining lanes are then emitted from an internal shift buffer.
//
// Ports:
//   i_clock   - system clock, rising edge
//   i_reset   - asynchronous, active-high reset
//   i_enable  - global enable; low freezes counter, buffer and o_data
//   i_valid   - output-slot strobe; each accepted strobe consumes one lane
//   i_data    - parallel bus; lane k = i_data[NB_DATA_BUS-1-k*LEN_CODED_BLOCK -: LEN_CODED_BLOCK]
//   o_load    - high when the next accepted strobe loads a new bus word
//   o_valid   - output block valid (registered accepted strobe)
//   o_data    - serialized block
//   o_lane_id - lane index of o_data. Present only when the macro
//               PARALLEL_CONVERTER_N_TO_1_LANE_ID_EN is defined.
// -----------------------------------------------------------------------------
module parallel_converter_n_to_1 #(
  parameter int LEN_CODED_BLOCK = 66,
  parameter int N_LANES         = 20,
  parameter int NB_DATA_BUS     = 1320
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_valid,
  input  logic [NB_DATA_BUS-1:0]     i_data,
  output logic                       o_load,
  output logic                       o_valid,
  output logic [LEN_CODED_BLOCK-1:0] o_data
`ifdef PARALLEL_CONVERTER_N_TO_1_LANE_ID_EN
  ,
  output logic [$clog2(N_LANES)-1:0] o_lane_id
`endif
);

  localparam int NB_COUNT = $clog2(N_LANES);
  localparam logic [NB_COUNT-1:0] LAST_LANE = NB_COUNT'(N_LANES - 1);

  logic [NB_COUNT-1:0]        count;
  logic [NB_COUNT-1:0]        count_next;
  logic [NB_DATA_BUS-1:0]     buffer;
  logic [NB_DATA_BUS-1:0]     buffer_next;
  logic [LEN_CODED_BLOCK-1:0] data_next;
  logic                       accept;
  logic                       at_load;

  always_comb begin
    accept      = i_enable & i_valid;
    at_load     = (count == '0);
    o_load      = at_load;
    count_next  = count;
    buffer_next = buffer;
    data_next   = o_data;
    if (accept) begin
      if (at_load) begin
        // Lane 0 goes straight out. Lanes 1..N-1 are parked MSB-aligned in the buffer.
        data_next   = i_data[NB_DATA_BUS-1 -: LEN_CODED_BLOCK];
        buffer_next = {i_data[NB_DATA_BUS-LEN_CODED_BLOCK-1:0], {LEN_CODED_BLOCK{1'b0}}};
      end else begin
        data_next   = buffer[NB_DATA_BUS-1 -: LEN_CODED_BLOCK];
        buffer_next = {buffer[NB_DATA_BUS-LEN_CODED_BLOCK-1:0], {LEN_CODED_BLOCK{1'b0}}};
      end
      count_next = (count == LAST_LANE) ? '0 : count + NB_COUNT'(1);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      count   <= '0;
      buffer  <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      count   <= count_next;
      buffer  <= buffer_next;
      o_data  <= data_next;
      o_valid <= accept;
    end
  end

`ifdef PARALLEL_CONVERTER_N_TO_1_LANE_ID_EN
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_lane_id <= '0;
    end else if (accept) begin
      o_lane_id <= count;
    end
  end
`endif

endmodule

// File: tb/tb_parallel_converter_n_to_1.sv
module tb_parallel_converter_n_to_1;

  localparam int LEN      = 66;
  localparam int N        = 20;
  localparam int NB       = LEN * N;
  localparam int NB_COUNT = $clog2(N);

  logic            tb_clock;
  logic            tb_reset;
  logic            tb_enable;
  logic            tb_valid;
  logic [NB-1:0]   tb_data;
  logic            o_load;
  logic            o_valid;
  logic [LEN-1:0]  o_data;
`ifdef PARALLEL_CONVERTER_N_TO_1_LANE_ID_EN
  logic [NB_COUNT-1:0] o_lane_id;
`endif

  parallel_converter_n_to_1 #(
    .LEN_CODED_BLOCK(LEN),
    .N_LANES(N),
    .NB_DATA_BUS(NB)
  ) dut (
    .i_clock (tb_clock),
    .i_reset (tb_reset),
    .i_enable(tb_enable),
    .i_valid (tb_valid),
    .i_data  (tb_data),
    .o_load  (o_load),
    .o_valid (o_valid),
    .o_data  (o_data)
`ifdef PARALLEL_CONVERTER_N_TO_1_LANE_ID_EN
    ,
    .o_lane_id(o_lane_id)
`endif
  );

  initial tb_clock = 1'b0;
  always #5 tb_clock = ~tb_clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the word captured at load time as an array of lanes,
  // and the index of the next lane to be emitted.
  logic [LEN-1:0] m_word [N];
  int             m_idx;
  logic           exp_valid;
  logic [LEN-1:0] exp_data;
  int             exp_lane;

  function automatic logic [LEN-1:0] lane_of(input logic [NB-1:0] bus, input int k);
    return bus[NB-1-k*LEN -: LEN];
  endfunction

  function automatic logic [NB-1:0] rand_bus();
    logic [NB-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < (NB + 31) / 32; i++) b = {b[NB-33:0], 32'($urandom)};
    return b;
  endfunction

  function automatic logic [NB-1:0] pattern_bus(input int w);
    logic [NB-1:0] b;
    b = '0;
    for (int k = 0; k < N; k++) b[NB-1-k*LEN -: LEN] = {34'(w), 32'(k + 1)};
    return b;
  endfunction

  // Advance one clock. The model consumes the inputs present at the edge.
  // The task returns 1 time unit after the edge, and outputs are sampled there.
  task automatic tick();
    @(posedge tb_clock);
    if (tb_enable && tb_valid) begin
      if (m_idx == 0)
        for (int k = 0; k < N; k++) m_word[k] = lane_of(tb_data, k);
      exp_data  = m_word[m_idx];
      exp_lane  = m_idx;
      exp_valid = 1'b1;
      m_idx     = (m_idx + 1) % N;
    end else begin
      exp_valid = 1'b0;
    end
    #1;
  endtask

  task automatic model_reset();
    m_idx     = 0;
    exp_valid = 1'b0;
    exp_data  = '0;
    exp_lane  = 0;
  endtask

  task automatic test_reset();
    tb_enable = 1'b1;
    tb_valid  = 1'b0;
    tb_data   = rand_bus();
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (o_valid !== 1'b0 || o_data !== '0 || o_load !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: o_valid=%b o_data=%h o_load=%b required 0/0/1",
                 c, o_valid, o_data, o_load);
      end
    end
  endtask

  task automatic test_back_to_back();
    int loads;
    loads     = 0;
    tb_enable = 1'b1;
    tb_valid  = 1'b1;
    for (int c = 0; c < 2 * N; c++) begin
      n_checks++;
      if (o_load !== (m_idx == 0)) begin
        n_fail++;
        $display("FAIL b2b_load strobe %0d: o_load=%b required %b", c, o_load, (m_idx == 0));
      end
      if (m_idx == 0) begin
        tb_data = pattern_bus(c / N + 1);
        loads++;
      end
      tick();
      n_checks++;
      if (o_valid !== 1'b1 || o_data !== {34'(c / N + 1), 32'(c % N + 1)}) begin
        n_fail++;
        $display("FAIL b2b_data strobe %0d: o_valid=%b o_data=%h required 1/%h",
                 c, o_valid, o_data, {34'(c / N + 1), 32'(c % N + 1)});
      end
`ifdef PARALLEL_CONVERTER_N_TO_1_LANE_ID_EN
      n_checks++;
      if (o_lane_id !== NB_COUNT'(c % N)) begin
        n_fail++;
        $display("FAIL b2b_lane_id strobe %0d: o_lane_id=%0d required %0d", c, o_lane_id, c % N);
      end
`endif
    end
    n_checks++;
    if (loads != 2 || o_load !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_load_count: loads=%0d o_load=%b required 2/1", loads, o_load);
    end
  endtask

  task automatic test_sparse();
    tb_enable = 1'b1;
    for (int c = 0; c < 2 * N * 20; c++) begin
      tb_valid = (c % 20 == 19);
      tb_data  = rand_bus();
      tick();
      n_checks++;
      if (o_valid !== exp_valid || o_data !== exp_data || o_load !== (m_idx == 0)) begin
        n_fail++;
        $display("FAIL sparse cycle %0d: o_valid=%b o_data=%h o_load=%b required %b/%h/%b",
                 c, o_valid, o_data, o_load, exp_valid, exp_data, (m_idx == 0));
      end
    end
  endtask

  task automatic test_mid_word_change();
    logic [NB-1:0] loaded;
    tb_enable = 1'b1;
    tb_valid  = 1'b1;
    tb_data   = rand_bus();
    loaded    = tb_data;
    for (int c = 0; c < N; c++) begin
      if (c == 8) tb_data = ~loaded;
      tick();
      n_checks++;
      if (o_valid !== 1'b1 || o_data !== lane_of(loaded, c)) begin
        n_fail++;
        $display("FAIL mid_word_change lane %0d: o_valid=%b o_data=%h required 1/%h",
                 c, o_valid, o_data, lane_of(loaded, c));
      end
    end
  endtask

  task automatic test_enable_gap();
    logic [LEN-1:0] held;
    tb_enable = 1'b1;
    tb_valid  = 1'b1;
    tb_data   = rand_bus();
    while (m_idx != 5) tick();
    held      = o_data;
    tb_enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if (o_valid !== 1'b0 || o_data !== held || o_load !== 1'b0) begin
        n_fail++;
        $display("FAIL enable_gap cycle %0d: o_valid=%b o_data=%h o_load=%b required 0/%h/0",
                 c, o_valid, o_data, o_load, held);
      end
    end
    tb_enable = 1'b1;
    for (int c = 5; c < N; c++) begin
      tick();
      n_checks++;
      if (o_valid !== 1'b1 || o_data !== m_word[c]) begin
        n_fail++;
        $display("FAIL enable_resume lane %0d: o_valid=%b o_data=%h required 1/%h",
                 c, o_valid, o_data, m_word[c]);
      end
`ifdef PARALLEL_CONVERTER_N_TO_1_LANE_ID_EN
      n_checks++;
      if (o_lane_id !== NB_COUNT'(c)) begin
        n_fail++;
        $display("FAIL enable_lane_id lane %0d: o_lane_id=%0d required %0d", c, o_lane_id, c);
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    tb_enable = 1'b1;
    tb_valid  = 1'b1;
    tb_data   = rand_bus();
    while (m_idx != 12) tick();
    tb_valid = 1'b0;
    #3 tb_reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (o_valid !== 1'b0 || o_data !== '0 || o_load !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: o_valid=%b o_data=%h o_load=%b required 0/0/1",
               o_valid, o_data, o_load);
    end
`ifdef PARALLEL_CONVERTER_N_TO_1_LANE_ID_EN
    n_checks++;
    if (o_lane_id !== '0) begin
      n_fail++;
      $display("FAIL async_reset_lane_id: o_lane_id=%0d required 0", o_lane_id);
    end
`endif
    #2 tb_reset = 1'b0;
    tb_data  = rand_bus();
    tb_valid = 1'b1;
    for (int c = 0; c < N; c++) begin
      tick();
      n_checks++;
      if (o_valid !== 1'b1 || o_data !== exp_data || exp_lane != c) begin
        n_fail++;
        $display("FAIL after_reset lane %0d: o_valid=%b o_data=%h required 1/%h",
                 c, o_valid, o_data, exp_data);
      end
    end
    n_checks++;
    if (m_word[0] !== lane_of(tb_data, 0)) begin
      n_fail++;
      $display("FAIL after_reset_load: captured lane0=%h required %h", m_word[0], lane_of(tb_data, 0));
    end
  endtask

  task automatic test_random();
    tb_enable = 1'b1;
    for (int c = 0; c < 300; c++) begin
      tb_enable = ($urandom_range(0, 7) != 0);
      tb_valid  = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) tb_data = rand_bus();
      tick();
      n_checks++;
      if (o_valid !== exp_valid || o_data !== exp_data || o_load !== (m_idx == 0)) begin
        n_fail++;
        $display("FAIL random cycle %0d: o_valid=%b o_data=%h o_load=%b required %b/%h/%b",
                 c, o_valid, o_data, o_load, exp_valid, exp_data, (m_idx == 0));
      end
    end
  endtask

  initial begin
    tb_reset  = 1'b1;
    tb_enable = 1'b0;
    tb_valid  = 1'b0;
    tb_data   = '0;
    model_reset();
    repeat (2) @(posedge tb_clock);
    #1 tb_reset = 1'b0;

    test_reset();
    test_back_to_back();
    test_sparse();
    test_mid_word_change();
    test_enable_gap();
    test_async_reset();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
